imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the LEGv8 pipelined datapath. It supersedes the single-cycle combinational sign-extender between fetch/IF-ID and decode. It decodes every immediate-carrying format: D (LDUR/STUR), CB (CBZ/CBNZ), B (B/BL), I (ADDI/SUBI) and IW (MOVZ). The result is registered behind a valid/ready handshake with a 2-entry skid buffer, so decode stalls never drop or duplicate instructions.

Parameters:
N, 64, output immediate width; legal range 32..64.
SHIFT_BRANCH, 0, 1 = CB/B offsets are output multiplied by 4 (<<2); 0 = raw word offset.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  instr is valid this cycle.
in_ready  output  1  block can accept instr this cycle.
instr  input  32  instruction word.
out_valid  output  1  imm/fmt/unknown are valid.
out_ready  input  1  consumer accepts the output this cycle.
imm  output  N  extended immediate.
fmt  output  3  format code (fmt_t).
unknown  output  1  opcode matched no supported format.
unknown_count  output  16  saturating count of unknown instructions delivered.

Behaviour:
- Reset: clk and reset are the single clock and its synchronous, active-high reset. While reset is high: out_valid=0, imm=0, fmt=FMT_NONE, unknown=0, unknown_count=0, in_ready=0, both entries empty. in_ready=1 on the first cycle after reset falls. Any in-flight or same-cycle input is discarded.
- Decode (combinational, on instr):
  - LDUR 11'b111_1100_0010 / STUR 11'b111_1100_0000: sign-extend instr[20:12] to N; fmt=FMT_D.
  - CBZ 8'b1011_0100 / CBNZ 8'b1011_0101: sign-extend instr[23:5]; fmt=FMT_CB.
  - B 6'b000101 / BL 6'b100101: sign-extend instr[25:0]; fmt=FMT_B.
  - ADDI 10'b1001000100 / SUBI 10'b1101000100: zero-extend instr[21:10]; fmt=FMT_I.
  - MOVZ 9'b110100101 (instr[31:23]): zero-extend instr[20:5], then shift left by 16*instr[22:21]. Bits beyond N-1 are dropped (N=32 with hw>=2 gives 0). fmt=FMT_IW.
  - Anything else: imm=0, fmt=FMT_NONE, unknown=1.
  - SHIFT_BRANCH=1: the CB/B result is shifted left 2 after extension, truncated to N.
- Handshake:
  - Input transfer when in_valid&&in_ready.
  - Output transfer when out_valid&&out_ready.
  - Latency is 1 cycle from the input transfer to out_valid.
  - Throughput is 1 instruction/cycle while out_ready=1.
- Stall behaviour:
  - While out_valid&&!out_ready, imm/fmt/unknown are held stable.
  - in_ready is registered: it is 0 exactly when the skid entry is full, so at most 2 instructions are buffered.
  - When the skid is full and the output transfers, the skid contents move to the output next cycle and in_ready returns to 1.
- Simultaneous input and output transfer in the same cycle: the new instruction replaces the output entry; no bubble is inserted.
- Order is strictly preserved. No loss, no duplication.
- unknown_count increments on each output transfer with unknown=1 and saturates at 16'hFFFF.

Decomposition:
- Package imm_gen_pkg holds:
  - fmt_t enum: FMT_NONE=0, FMT_D, FMT_CB, FMT_B, FMT_I, FMT_IW.
  - Opcode localparams: OP_LDUR, OP_STUR, OP_CBZ, OP_CBNZ, OP_B, OP_BL, OP_ADDI, OP_SUBI, OP_MOVZ.
  - Packed struct imm_entry_t {imm, fmt, unknown}.
- Sub-module imm_decode: purely combinational, parametrised on N and SHIFT_BRANCH. It produces imm_entry_t.
- imm_gen_pipe contains the output register, the skid register and the counter.

Test Plan:
- LDUR 32'hF842D335 then STUR 32'hF818CABC, out_ready=1:
  - Outputs appear 1 cycle after each accept: imm=64'h2D (FMT_D), then 64'hFFFF_FFFF_FFFF_FF8C (FMT_D).
- CBZ 32'hB4FFFFC3 and B 32'h17FFFFFF:
  - SHIFT_BRANCH=0: imm=64'hFFFF_FFFF_FFFF_FFFE (FMT_CB), then 64'hFFFF_FFFF_FFFF_FFFF (FMT_B).
  - SHIFT_BRANCH=1: 64'hFFFF_FFFF_FFFF_FFF8, then 64'hFFFF_FFFF_FFFF_FFFC.
- MOVZ 32'hD2B579A0: N=64 gives imm=64'h0000_0000_ABCD_0000, FMT_IW. Same hw=1 case with N=32 gives 32'hABCD_0000.
- Unknown inputs 32'h0, 32'h1: imm=0, unknown=1 each, unknown_count=2. Pre-load the counter near saturation and confirm it sticks at 16'hFFFF.
- Backpressure: send 4 back-to-back instructions with out_ready=0 for 3 cycles.
  - in_ready drops after 2 accepts and the output stays stable during the stall.
  - After releasing out_ready, all 4 outputs emerge in order with no loss or duplication.
- Reset mid-stream: assert reset while 2 entries are buffered.
  - Next cycle: out_valid=0, unknown_count=0, in_ready=0.
  - in_ready=1 in the cycle after reset falls, and the buffered entries never appear.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the LEGv8 pipelined immediate generator.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_D    = 3'd1,
        FMT_CB   = 3'd2,
        FMT_B    = 3'd3,
        FMT_I    = 3'd4,
        FMT_IW   = 3'd5
    } fmt_t;

    localparam logic [10:0] OP_LDUR = 11'b111_1100_0010;
    localparam logic [10:0] OP_STUR = 11'b111_1100_0000;
    localparam logic [7:0]  OP_CBZ  = 8'b1011_0100;
    localparam logic [7:0]  OP_CBNZ = 8'b1011_0101;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [5:0]  OP_BL   = 6'b100101;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;

    // imm is always carried at full 64-bit width; bits at and above N are zero.
    typedef struct packed {
        logic [63:0] imm;
        fmt_t        fmt;
        logic        unknown;
    } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational opcode decode and immediate extension for all immediate formats.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int N            = 64,
    parameter bit SHIFT_BRANCH = 1'b0
)
(
    input  logic [31:0] instr,
    output imm_entry_t  entry
);

    localparam logic [63:0] WIDTH_MASK = (N >= 64) ? {64{1'b1}} : ((64'd1 << N) - 64'd1);

    logic [63:0] raw_imm;
    fmt_t        fmt_sel;
    logic        unknown_sel;

    always_comb begin
        raw_imm     = '0;
        fmt_sel     = FMT_NONE;
        unknown_sel = 1'b0;
        if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
            raw_imm = {{55{instr[20]}}, instr[20:12]};
            fmt_sel = FMT_D;
        end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ) begin
            raw_imm = {{45{instr[23]}}, instr[23:5]};
            if (SHIFT_BRANCH) raw_imm = raw_imm << 2;
            fmt_sel = FMT_CB;
        end else if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
            raw_imm = {{38{instr[25]}}, instr[25:0]};
            if (SHIFT_BRANCH) raw_imm = raw_imm << 2;
            fmt_sel = FMT_B;
        end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
            raw_imm = {52'd0, instr[21:10]};
            fmt_sel = FMT_I;
        end else if (instr[31:23] == OP_MOVZ) begin
            // hw field selects a 16-bit lane; lanes beyond N are removed by the mask
            raw_imm = {48'd0, instr[20:5]} << {instr[22:21], 4'b0000};
            fmt_sel = FMT_IW;
        end else begin
            unknown_sel = 1'b1;
        end
    end

    assign entry.imm     = raw_imm & WIDTH_MASK;
    assign entry.fmt     = fmt_sel;
    assign entry.unknown = unknown_sel;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and a one-deep skid entry.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int N            = 64,
    parameter bit SHIFT_BRANCH = 1'b0
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] imm,
    output logic [2:0]   fmt,
    output logic         unknown,
    output logic [15:0]  unknown_count
);

    imm_entry_t  dec_entry;
    imm_entry_t  out_entry_reg, out_entry_next;
    imm_entry_t  skid_entry_reg, skid_entry_next;
    logic        out_valid_reg, out_valid_next;
    logic        skid_valid_reg, skid_valid_next;
    logic        in_ready_reg;
    logic [15:0] unknown_count_reg, unknown_count_next;
    logic        in_fire, out_fire;

    imm_decode #(.N(N), .SHIFT_BRANCH(SHIFT_BRANCH)) u_decode (
        .instr (instr),
        .entry (dec_entry)
    );

    assign in_fire  = in_valid && in_ready_reg;
    assign out_fire = out_valid_reg && out_ready;

    always_comb begin
        out_entry_next     = out_entry_reg;
        out_valid_next     = out_valid_reg;
        skid_entry_next    = skid_entry_reg;
        skid_valid_next    = skid_valid_reg;
        unknown_count_next = unknown_count_reg;
        if (!out_valid_reg || out_fire) begin
            // Output slot frees up: the older skid entry always wins over new input.
            if (skid_valid_reg) begin
                out_entry_next  = skid_entry_reg;
                out_valid_next  = 1'b1;
                skid_valid_next = 1'b0;
            end else if (in_fire) begin
                out_entry_next = dec_entry;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (in_fire) begin
            skid_entry_next = dec_entry;
            skid_valid_next = 1'b1;
        end
        if (out_fire && out_entry_reg.unknown && unknown_count_reg != 16'hFFFF)
            unknown_count_next = unknown_count_reg + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_entry_reg     <= '0;
            out_valid_reg     <= 1'b0;
            skid_entry_reg    <= '0;
            skid_valid_reg    <= 1'b0;
            in_ready_reg      <= 1'b0;
            unknown_count_reg <= '0;
        end else begin
            out_entry_reg     <= out_entry_next;
            out_valid_reg     <= out_valid_next;
            skid_entry_reg    <= skid_entry_next;
            skid_valid_reg    <= skid_valid_next;
            in_ready_reg      <= !skid_valid_next;
            unknown_count_reg <= unknown_count_next;
        end
    end

    assign in_ready      = in_ready_reg;
    assign out_valid     = out_valid_reg;
    assign imm           = out_entry_reg.imm[N-1:0];
    assign fmt           = out_entry_reg.fmt;
    assign unknown       = out_entry_reg.unknown;
    assign unknown_count = unknown_count_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed-vector bench for imm_gen_pipe: default, branch-shifted and 32-bit builds.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, unknown;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [15:0] unknown_count;

    logic        sb_in_ready, sb_out_valid, sb_unknown;
    logic [63:0] sb_imm;
    logic [2:0]  sb_fmt;
    logic [15:0] sb_unknown_count;

    logic        n32_in_ready, n32_out_valid, n32_unknown;
    logic [31:0] n32_imm;
    logic [2:0]  n32_fmt;
    logic [15:0] n32_unknown_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.N(64), .SHIFT_BRANCH(1'b0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .fmt(fmt), .unknown(unknown), .unknown_count(unknown_count)
    );

    imm_gen_pipe #(.N(64), .SHIFT_BRANCH(1'b1)) dut_sb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(sb_in_ready),
        .instr(instr), .out_valid(sb_out_valid), .out_ready(out_ready),
        .imm(sb_imm), .fmt(sb_fmt), .unknown(sb_unknown), .unknown_count(sb_unknown_count)
    );

    imm_gen_pipe #(.N(32), .SHIFT_BRANCH(1'b0)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n32_in_ready),
        .instr(instr), .out_valid(n32_out_valid), .out_ready(out_ready),
        .imm(n32_imm), .fmt(n32_fmt), .unknown(n32_unknown), .unknown_count(n32_unknown_count)
    );

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; instr = 32'hF842D335; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || imm !== 64'd0 || fmt !== 3'd0 ||
            unknown !== 1'b0 || unknown_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b rdy=%b imm=%h fmt=%0d unk=%b cnt=%h, want 0/0/0/0/0/0",
                     out_valid, in_ready, imm, fmt, unknown, unknown_count);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_store();
        logic [31:0] ins [2];
        logic [63:0] exp [2];
        ins[0] = 32'hF842D335; exp[0] = 64'h2D;
        ins[1] = 32'hF818CABC; exp[1] = 64'hFFFF_FFFF_FFFF_FF8C;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; instr = ins[i];
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || imm !== exp[i] || fmt !== FMT_D || unknown !== 1'b0) begin
                miscompares++;
                $display("FAIL d_format[%0d]: got v=%b imm=%h fmt=%0d unk=%b, want 1 imm=%h fmt=%0d unk=0",
                         i, out_valid, imm, fmt, unknown, exp[i], FMT_D);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL d_drain: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [2];
        logic [63:0] exp [2];
        logic [63:0] exp_sb [2];
        logic [2:0]  exp_fmt [2];
        ins[0] = 32'hB4FFFFC3; exp[0] = 64'hFFFF_FFFF_FFFF_FFFE; exp_sb[0] = 64'hFFFF_FFFF_FFFF_FFF8; exp_fmt[0] = FMT_CB;
        ins[1] = 32'h17FFFFFF; exp[1] = 64'hFFFF_FFFF_FFFF_FFFF; exp_sb[1] = 64'hFFFF_FFFF_FFFF_FFFC; exp_fmt[1] = FMT_B;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; instr = ins[i];
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || imm !== exp[i] || fmt !== exp_fmt[i]) begin
                miscompares++;
                $display("FAIL branch_raw[%0d]: got v=%b imm=%h fmt=%0d, want 1 imm=%h fmt=%0d",
                         i, out_valid, imm, fmt, exp[i], exp_fmt[i]);
            end
            vectors++;
            if (sb_imm !== exp_sb[i] || sb_fmt !== exp_fmt[i]) begin
                miscompares++;
                $display("FAIL branch_shift[%0d]: got imm=%h fmt=%0d, want imm=%h fmt=%0d",
                         i, sb_imm, sb_fmt, exp_sb[i], exp_fmt[i]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_movz_addi();
        logic [31:0] ins [3];
        logic [63:0] exp [3];
        logic [31:0] exp32 [3];
        logic [2:0]  exp_fmt [3];
        ins[0] = 32'hD2B579A0;                                   exp[0] = 64'h0000_0000_ABCD_0000;
        exp32[0] = 32'hABCD_0000; exp_fmt[0] = FMT_IW;
        ins[1] = {9'b110100101, 2'b11, 16'hABCD, 5'd0};          exp[1] = 64'hABCD_0000_0000_0000;
        exp32[1] = 32'h0;         exp_fmt[1] = FMT_IW;
        ins[2] = {10'b1001000100, 12'hFFF, 10'd0};               exp[2] = 64'h0000_0000_0000_0FFF;
        exp32[2] = 32'h0000_0FFF; exp_fmt[2] = FMT_I;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; instr = ins[i];
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || imm !== exp[i] || fmt !== exp_fmt[i] || unknown !== 1'b0) begin
                miscompares++;
                $display("FAIL wide_imm[%0d]: got v=%b imm=%h fmt=%0d unk=%b, want 1 imm=%h fmt=%0d unk=0",
                         i, out_valid, imm, fmt, unknown, exp[i], exp_fmt[i]);
            end
            vectors++;
            if (n32_imm !== exp32[i] || n32_fmt !== exp_fmt[i]) begin
                miscompares++;
                $display("FAIL n32_imm[%0d]: got imm=%h fmt=%0d, want imm=%h fmt=%0d",
                         i, n32_imm, n32_fmt, exp32[i], exp_fmt[i]);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unknown();
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; instr = i;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || imm !== 64'd0 || fmt !== FMT_NONE || unknown !== 1'b1) begin
                miscompares++;
                $display("FAIL unknown[%0d]: got v=%b imm=%h fmt=%0d unk=%b, want 1 imm=0 fmt=0 unk=1",
                         i, out_valid, imm, fmt, unknown);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (unknown_count !== 16'd2) begin
            miscompares++;
            $display("FAIL unknown_count: got %h, want 0002", unknown_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic acc, del;
        for (int i = 0; i < 4; i++) ins[i] = {11'h7C2, 9'(i + 1), 12'd0};
        while (cyc < 20) begin
            in_valid  = (sent < 4);
            instr     = (sent < 4) ? ins[sent] : 32'd0;
            out_ready = (cyc >= 3);
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (cyc >= 1 && cyc <= 3) begin
                vectors++;
                if (out_valid !== 1'b1 || imm !== 64'd1) begin
                    miscompares++;
                    $display("FAIL stall_hold cyc%0d: got v=%b imm=%h, want 1 imm=1", cyc, out_valid, imm);
                end
            end
            if (cyc == 2 || cyc == 3) begin
                vectors++;
                if (in_ready !== 1'b0 || sent != 2) begin
                    miscompares++;
                    $display("FAIL stall_ready cyc%0d: got in_ready=%b accepted=%0d, want 0 and 2", cyc, in_ready, sent);
                end
            end
            if (cyc == 4) begin
                vectors++;
                if (in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ready_return: got in_ready=%b, want 1", in_ready);
                end
            end
            if (del) begin
                vectors++;
                if (got >= 4 || imm !== 64'(got + 1)) begin
                    miscompares++;
                    $display("FAIL order[%0d]: got imm=%h, want %h", got, imm, 64'(got + 1));
                end
                got++;
            end
            if (acc) sent++;
            @(negedge clk);
            cyc++;
            if (got >= 4 && sent >= 4 && !out_valid) break;
        end
        vectors++;
        if (got != 4 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_count: got %0d outputs out_valid=%b, want 4 and 0", got, out_valid);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        out_ready = 1'b1; instr = 32'd0;
        // counter is 2 here; 65532 more deliveries reach 16'hFFFE
        for (int i = 0; i < 65532; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (unknown_count !== 16'hFFFE) begin
            miscompares++;
            $display("FAIL count_near_sat: got %h, want FFFE", unknown_count);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (unknown_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL count_saturate: got %h, want FFFF", unknown_count);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = {11'h7C2, 9'd5, 12'd0};
        @(negedge clk);
        instr = {11'h7C2, 9'd6, 12'd0};
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL preload_full: got in_ready=%b out_valid=%b, want 0/1", in_ready, out_valid);
        end
        reset = 1'b1; in_valid = 1'b1; instr = 32'hF842D335; out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || unknown_count !== 16'd0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midstream_reset: got v=%b cnt=%h rdy=%b, want 0/0000/0", out_valid, unknown_count, in_ready);
        end
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midstream_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL ghost_output cyc%0d: got out_valid=%b imm=%h, want 0", i, out_valid, imm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_branch();
        test_movz_addi();
        test_unknown();
        test_back_to_back();
        test_saturation();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
